// File: rtl/decoder_pkg.sv
// Shared encodings for the decoder pipeline: request modes, scan FSM states
// and the width of one buffered {err, data} beat.
package decoder_pkg;

    typedef enum logic [1:0] {
        MODE_ONEHOT = 2'd0,
        MODE_THERM  = 2'd1,
        MODE_SCAN   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_e;

    function automatic int beat_width(input int out_w);
        return out_w + 1;
    endfunction

endpackage

// File: rtl/decoder_fifo2.sv
// Two-entry FIFO for decoded beats. An empty FIFO presents all-zero data, so
// the consumer side shows a clean zero beat whenever nothing is buffered.
module decoder_fifo2 #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);

    logic [W-1:0] mem_q [2];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   count_q;
    logic         do_push;
    logic         do_pop;

    assign do_push = push && (count_q != 2'd2);
    assign do_pop  = pop && (count_q != 2'd0);

    // Storage needs no reset: reads are masked while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout  = (count_q == 2'd0) ? '0 : mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/decoder_pipe.sv
// Flow-controlled select decoder: one-hot, thermometer or a multi-beat scan
// walk over all output lines, buffered through a 2-entry output FIFO.
module decoder_pipe
    import decoder_pkg::*;
#(
    parameter int SEL_W = 3,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_err
);

    localparam int BW = beat_width(OUT_W);

    state_e           state_q, state_d;
    logic [SEL_W-1:0] idx_q, idx_d;
    logic [SEL_W-1:0] rem_q, rem_d;
    logic [OUT_W-1:0] onehot_pat, therm_pat, scan_pat;
    logic             sel_bad;
    logic             accept;
    logic             push;
    logic             pop;
    logic [BW-1:0]    push_beat;
    logic [BW-1:0]    pop_beat;
    logic [1:0]       count;

    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
        return (32'(v) == 32'(OUT_W - 1)) ? '0 : v + SEL_W'(1);
    endfunction

    for (genvar gi = 0; gi < OUT_W; gi++) begin : g_pat
        assign onehot_pat[gi] = (in_sel == SEL_W'(gi));
        assign therm_pat[gi]  = (32'(in_sel) >= 32'(gi));
        assign scan_pat[gi]   = (idx_q == SEL_W'(gi));
    end

    assign sel_bad   = (32'(in_sel) >= 32'(OUT_W));
    // rst_n gating keeps the input side closed for the whole reset pulse.
    assign in_ready  = rst_n && (state_q == ST_IDLE) && (count != 2'd2);
    assign accept    = in_valid && in_ready;
    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign {out_err, out_data} = pop_beat;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rem_d     = rem_q;
        push      = 1'b0;
        push_beat = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    push = 1'b1;
                    case (mode_e'(in_mode))
                        MODE_ONEHOT: push_beat = sel_bad ? {1'b1, {OUT_W{1'b0}}} : {1'b0, onehot_pat};
                        MODE_THERM:  push_beat = sel_bad ? {1'b1, {OUT_W{1'b1}}} : {1'b0, therm_pat};
                        MODE_SCAN: begin
                            push_beat = sel_bad ? {1'b1, {OUT_W{1'b0}}} : {1'b0, onehot_pat};
                            if (!sel_bad) begin
                                state_d = ST_SCAN;
                                idx_d   = wrap_inc(in_sel);
                                rem_d   = SEL_W'(OUT_W - 1);
                            end
                        end
                        default:     push_beat = {1'b1, {OUT_W{1'b0}}};
                    endcase
                end
            end
            ST_SCAN: begin
                // idx_q is the next line to emit, rem_q the beats still owed.
                if (count != 2'd2) begin
                    push      = 1'b1;
                    push_beat = {1'b0, scan_pat};
                    idx_d     = wrap_inc(idx_q);
                    rem_d     = rem_q - SEL_W'(1);
                    if (rem_q == SEL_W'(1)) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
        end
    end

    decoder_fifo2 #(
        .W(BW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   (push_beat),
        .dout  (pop_beat),
        .count (count)
    );

endmodule

// File: doc/decoder_pipe.md
# decoder_pipe

Parametrised, flow-controlled successor to the team's fixed 3-to-8 one-hot decoder. It turns an SEL_W-bit select into an OUT_W-bit pattern in one of three modes: one-hot, thermometer, or scan. Scan mode is a multi-beat walk that emits every output line once. Results pass through a 2-entry output buffer with valid/ready on both sides, so the block can sit between stalling producers and consumers in the datapath.

## Interface
- SEL_W, 3, select width; must be ≥1.
- OUT_W, 8, output width; must satisfy 2 ≤ OUT_W ≤ 2**SEL_W.
- clk  in  1  single clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request this cycle.
- in_sel  in  SEL_W  select index; start index in scan mode.
- in_mode  in  2  0 = ONEHOT, 1 = THERM, 2 = SCAN, 3 = reserved.
- out_valid  out  1  out_data/out_err hold a beat.
- out_ready  in  1  consumer takes the beat.
- out_data  out  OUT_W  decoded pattern.
- out_err  out  1  beat flags an illegal request.

## Operation
- A request is accepted when in_valid && in_ready. A beat leaves the block when out_valid && out_ready.
- ONEHOT: out_data bit in_sel = 1, all other bits 0.
- THERM: out_data bits [in_sel:0] = 1, upper bits 0.
- SCAN: the request expands into OUT_W beats with one-hot index start, start+1, …, wrapping from OUT_W-1 to 0 until all OUT_W indices have been emitted.
- Error cases, each producing exactly one beat:
  - ONEHOT with in_sel ≥ OUT_W: beat = {data 0, err 1}.
  - THERM with in_sel ≥ OUT_W: beat = {data all-ones, err 1}.
  - SCAN with start ≥ OUT_W: beat = {data 0, err 1}; no walk.
  - Mode 3: beat = {data 0, err 1}.
- All legal beats carry err = 0.
- FSM has two states:
  - IDLE: in_ready = (buffer count < 2). Non-scan requests push their single beat on the accept edge. A legal SCAN request pushes index start and moves to SCAN with remaining = OUT_W-1.
  - SCAN: in_ready = 0. Push the next index whenever count < 2 (pop allowed in the same cycle). Decrement remaining on each push. When remaining reaches 0, return to IDLE on that edge.
- Buffer is a 2-entry FIFO of {data, err}.
  - in_ready is computed from count only. When full, a same-cycle pop does not allow an accept.
  - Simultaneous push and pop when count = 1 leaves count at 1 and preserves order.
- With the buffer empty: out_valid = 0, out_data = 0, out_err = 0.
- Reset (async assert, at any time, including mid-scan):
  - state = IDLE, buffer cleared, scan counters cleared.
  - out_valid = 0, out_data = 0, out_err = 0, in_ready = 0 while rst_n is low.
  - in_ready = 1 on the first cycle after deassertion.
  - An interrupted scan is discarded and not resumed.

## Timing
- Latency: a request accepted at edge k produces out_valid = 1 in cycle k+1 when the buffer was empty.
- Sustained throughput: 1 beat/cycle with out_ready held high, in both IDLE and SCAN.
- A SCAN request occupies the input for OUT_W-1 cycles after its accept edge at minimum, longer under backpressure.
- out_data/out_err hold stable while out_valid && !out_ready.
- No combinational path from in_* to out_*. in_ready depends only on state and count; out_ready does not feed in_ready.

## Structure
- Package decoder_pkg holds:
  - mode encodings (ONEHOT, THERM, SCAN, RSVD) as a 2-bit enum;
  - FSM state enum (IDLE, SCAN);
  - a beat struct width helper (OUT_W+1).
- Sub-module decoder_fifo2: a parametrised 2-entry FIFO (width OUT_W+1) with push/pop/count. It is instantiated once.
- Top level holds pattern generation, the scan FSM and the remaining/index counters (index width SEL_W, wraps at OUT_W).

## Test plan
- Defaults, ONEHOT sel 3→6 back-to-back, out_ready = 1 → beats 8'h08 then 8'h40, err 0, each one cycle after its accept.
- THERM sel 2 → 8'h07, err 0. With OUT_W = 6, ONEHOT sel 7 → data 0, err 1. With OUT_W = 6, THERM sel 6 → data 6'h3F, err 1.
- SCAN start 6, out_ready = 1 → 8 consecutive beats 8'h40, 8'h80, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20. in_ready low until the last push.
- Backpressure: out_ready = 0 with 3 ONEHOT requests offered → 2 accepted, in_ready = 0, out_data held. Raising out_ready drains in order, then the third request is accepted.
- Mode 3 request → single beat {0, err 1}; the next request decodes normally.
- rst_n pulsed low during SCAN, 2 beats into the walk → out_valid drops immediately. After release in_ready = 1, buffer empty, and a new ONEHOT sel 0 yields 8'h01.
